apb_master_ctrl: RTL and testbench
==================================

Name: apb_master_ctrl

Overview:
- Sequencing controller that drives the APB interface block from a simple pipelined request port on the bridge side.
- Accepts one request per handshake, decodes the address into a one-hot psel and runs the APB SETUP -> ACCESS protocol.
- Returns read data, and flags decode errors.
- Sits between the bridge request logic and the APB interface, and owns all timing of pwrite, penable, psel, paddr and pwdata.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TAG_HI, 31, MSB of the 6-bit region tag taken from haddr[TAG_HI:TAG_HI-5]
- BASE_TAG, 6'b100000, region tag of slave 0; slaves 1 and 2 are BASE_TAG+1 and BASE_TAG+2
- CNT_W, 16, width of the completed-transfer counter

Ports:
- hclk  in  1  system clock, rising edge
- hreset  in  1  asynchronous, active-high reset
- valid  in  1  request present
- hwrite  in  1  1 = write, 0 = read
- haddr  in  ADDR_W  request address
- hwdata  in  DATA_W  write data, sampled with the request
- prdata  in  DATA_W  read data returned by the APB side
- hready_out  out  1  controller can accept a request this cycle
- hrdata  out  DATA_W  registered read data
- rd_valid  out  1  one-cycle pulse; hrdata is valid
- herr  out  1  one-cycle pulse; the request decoded to no slave
- pwrite  out  1  APB write strobe
- penable  out  1  APB enable
- psel  out  3  one-hot APB slave select
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- xfer_cnt  out  CNT_W  count of completed APB transfers

Behaviour:
- Reset (async, active-high, returns immediately, even mid-transfer):
  - state = IDLE
  - hready_out = 1
  - psel = 0, penable = 0, pwrite = 0
  - paddr = 0, pwdata = 0, hrdata = 0
  - rd_valid = 0, herr = 0, xfer_cnt = 0
- Handshake: a request is accepted on a rising edge where valid && hready_out are both 1.
  - On acceptance, haddr, hwrite and hwdata are registered into paddr, pwrite and pwdata.
  - These registers hold unchanged until the next acceptance.
- Decode, on the region tag t = haddr[TAG_HI:TAG_HI-5]:
  - t == BASE_TAG -> psel 3'b001
  - t == BASE_TAG+1 -> psel 3'b010
  - t == BASE_TAG+2 -> psel 3'b100
  - any other tag -> decode miss
- Decode miss on acceptance:
  - No APB cycle; state is unchanged.
  - herr = 1 in the following cycle only; hready_out stays 1.
  - paddr, pwrite and pwdata are not updated.
- State machine:
  - IDLE: hready_out = 1, psel = 0, penable = 0. A valid hit moves to SETUP.
  - SETUP (exactly 1 cycle): psel = decoded value, penable = 0, hready_out = 0. Always moves to ACCESS.
  - ACCESS (exactly 1 cycle; this APB has no wait states): psel held, penable = 1, hready_out = 1.
    - A new valid hit accepted here moves to SETUP (back-to-back transfer).
    - A decode miss accepted here moves to IDLE and raises herr next cycle.
    - No request moves to IDLE.
- Throughput: 2 cycles per transfer, with no idle cycle between back-to-back transfers.
- Read return:
  - At the end of ACCESS with pwrite = 0: hrdata <= prdata and rd_valid = 1 for the next cycle.
  - hrdata holds its value until the next read.
  - Writes never change hrdata.
- xfer_cnt:
  - Increments by 1 at the end of every ACCESS cycle.
  - Saturates at all-ones; it does not wrap.
  - Decode misses are not counted.
- Simultaneous events: a read completion and a new acceptance in the same ACCESS cycle are both honoured. rd_valid pulses while the new SETUP is in progress.
- psel and penable are registered outputs and are glitch-free. penable is never 1 unless psel is non-zero.
- valid while hready_out = 0 (during SETUP) is ignored; the requester must hold the request.

Test Plan:
- Reset state: assert hreset mid-SETUP -> same cycle psel = 0, penable = 0, hready_out = 1, xfer_cnt = 0.
- Single write: haddr = 32'h8000_0010, hwdata = 32'hA5A5_0001, hwrite = 1 -> SETUP psel = 001, penable = 0, then ACCESS penable = 1, pwdata = A5A5_0001, xfer_cnt = 1.
- Read with return data: haddr = 32'h8800_0004, hwrite = 0, prdata = 32'd25 in ACCESS -> psel = 100 across 2 cycles, then hrdata = 25 with rd_valid pulsed for 1 cycle.
- Back-to-back traffic: write to 0x8400_0000 followed by a read to 0x8000_0008 with valid held high -> SETUP/ACCESS/SETUP/ACCESS with no IDLE cycle, psel 010 then 001, xfer_cnt = 2.
- Decode miss: haddr = 32'h1234_0000 -> no psel or penable activity, herr pulses 1 cycle, xfer_cnt unchanged, hready_out stays 1.
- Counter saturation: preload-equivalent run of 65535 transfers plus 1 more -> xfer_cnt stays at 16'hFFFF.

Source files
------------

// File: rtl/apb_master_ctrl.sv
// APB master sequencer: takes one request per valid/hready_out handshake,
// decodes the region tag into a one-hot psel and runs SETUP -> ACCESS.
// Read data is registered on ACCESS completion. Requests to unmapped regions
// raise a one-cycle herr pulse. Completed transfers are counted, and the
// counter saturates.
//
// state  | meaning
// IDLE   | no transfer in progress, ready for a request
// SETUP  | psel driven, penable low, requests are not accepted
// ACCESS | penable high, transfer completes, the next request may be accepted
module apb_master_ctrl #(
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32,
  parameter int          TAG_HI   = 31,
  parameter logic [5:0]  BASE_TAG = 6'b100000,
  parameter int          CNT_W    = 16
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              valid,
  input  logic              hwrite,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] prdata,
  output logic              hready_out,
  output logic [DATA_W-1:0] hrdata,
  output logic              rd_valid,
  output logic              herr,
  output logic              pwrite,
  output logic              penable,
  output logic [2:0]        psel,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic [CNT_W-1:0]  xfer_cnt
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t              state_q, state_d;
  logic [2:0]          psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [DATA_W-1:0]   hrdata_q, hrdata_d;
  logic                rd_valid_q, rd_valid_d;
  logic                herr_q, herr_d;
  logic [CNT_W-1:0]    xfer_cnt_q, xfer_cnt_d;

  logic [5:0]          tag;
  logic [2:0]          dec_sel;
  logic                accept;
  logic                hit;

  // Region tag decode to a one-hot slave select; all-zero means no slave.
  always_comb begin
    tag     = haddr[TAG_HI -: 6];
    dec_sel = 3'b000;
    if (tag == BASE_TAG)              dec_sel = 3'b001;
    else if (tag == BASE_TAG + 6'd1)  dec_sel = 3'b010;
    else if (tag == BASE_TAG + 6'd2)  dec_sel = 3'b100;
  end

  assign hready_out = (state_q != SETUP);
  assign accept     = valid && hready_out;
  assign hit        = (dec_sel != 3'b000);

  // Next-state, APB strobes, request capture, read return and counter.
  always_comb begin
    state_d    = state_q;
    psel_d     = psel_q;
    penable_d  = 1'b0;
    pwrite_d   = pwrite_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    hrdata_d   = hrdata_q;
    rd_valid_d = 1'b0;
    herr_d     = 1'b0;
    xfer_cnt_d = xfer_cnt_q;

    case (state_q)
      IDLE: begin
        psel_d = 3'b000;
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        state_d = IDLE;
        psel_d  = 3'b000;
        if (xfer_cnt_q != {CNT_W{1'b1}}) xfer_cnt_d = xfer_cnt_q + 1'b1;
        if (!pwrite_q) begin
          hrdata_d   = prdata;
          rd_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        psel_d  = 3'b000;
      end
    endcase

    // Acceptance is only possible in IDLE or ACCESS, since hready_out is low in SETUP.
    if (accept) begin
      if (hit) begin
        state_d  = SETUP;
        psel_d   = dec_sel;
        pwrite_d = hwrite;
        paddr_d  = haddr;
        pwdata_d = hwdata;
      end else begin
        herr_d = 1'b1;
      end
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q    <= IDLE;
      psel_q     <= 3'b000;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      hrdata_q   <= '0;
      rd_valid_q <= 1'b0;
      herr_q     <= 1'b0;
      xfer_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      pwrite_q   <= pwrite_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      hrdata_q   <= hrdata_d;
      rd_valid_q <= rd_valid_d;
      herr_q     <= herr_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign psel     = psel_q;
  assign penable  = penable_q;
  assign pwrite   = pwrite_q;
  assign paddr    = paddr_q;
  assign pwdata   = pwdata_q;
  assign hrdata   = hrdata_q;
  assign rd_valid = rd_valid_q;
  assign herr     = herr_q;
  assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl. A second instance with a 4-bit counter
// shares all inputs, so that saturation is reached within a short run.
module tb_apb_master_ctrl;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        valid;
  logic        hwrite;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [31:0] prdata;

  logic        hready_out, rd_valid, herr, pwrite, penable;
  logic [31:0] hrdata, paddr, pwdata;
  logic [2:0]  psel;
  logic [15:0] xfer_cnt;

  logic        s_hready_out, s_rd_valid, s_herr, s_pwrite, s_penable;
  logic [31:0] s_hrdata, s_paddr, s_pwdata;
  logic [2:0]  s_psel;
  logic [3:0]  s_xfer_cnt;

  int checks = 0;
  int errors = 0;

  always #5 hclk = ~hclk;

  apb_master_ctrl dut (
    .hclk(hclk), .hreset(hreset), .valid(valid), .hwrite(hwrite),
    .haddr(haddr), .hwdata(hwdata), .prdata(prdata),
    .hready_out(hready_out), .hrdata(hrdata), .rd_valid(rd_valid),
    .herr(herr), .pwrite(pwrite), .penable(penable), .psel(psel),
    .paddr(paddr), .pwdata(pwdata), .xfer_cnt(xfer_cnt)
  );

  apb_master_ctrl #(.CNT_W(4)) dut_sat (
    .hclk(hclk), .hreset(hreset), .valid(valid), .hwrite(hwrite),
    .haddr(haddr), .hwdata(hwdata), .prdata(prdata),
    .hready_out(s_hready_out), .hrdata(s_hrdata), .rd_valid(s_rd_valid),
    .herr(s_herr), .pwrite(s_pwrite), .penable(s_penable), .psel(s_psel),
    .paddr(s_paddr), .pwdata(s_pwdata), .xfer_cnt(s_xfer_cnt)
  );

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic test_reset();
    hreset = 1'b1; valid = 1'b0; hwrite = 1'b0;
    haddr = '0; hwdata = '0; prdata = '0;
    step(); step();
    hreset = 1'b0;
    step();
    checks++; if (psel !== 3'b000) begin errors++; $display("FAIL reset_psel got %b exp 000", psel); end
    checks++; if (penable !== 1'b0) begin errors++; $display("FAIL reset_penable got %b exp 0", penable); end
    checks++; if (hready_out !== 1'b1) begin errors++; $display("FAIL reset_hready got %b exp 1", hready_out); end
    checks++; if (xfer_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", xfer_cnt); end
    checks++; if ({paddr, pwdata, hrdata} !== 96'd0) begin errors++; $display("FAIL reset_regs got %h %h %h exp 0", paddr, pwdata, hrdata); end
    checks++; if ({rd_valid, herr, pwrite} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b exp 000", {rd_valid, herr, pwrite}); end
  endtask

  task automatic test_single_write();
    valid = 1'b1; hwrite = 1'b1; haddr = 32'h8000_0010; hwdata = 32'hA5A5_0001;
    step();
    valid = 1'b0;
    checks++; if (psel !== 3'b001) begin errors++; $display("FAIL wr_setup_psel got %b exp 001", psel); end
    checks++; if (penable !== 1'b0) begin errors++; $display("FAIL wr_setup_penable got %b exp 0", penable); end
    checks++; if (hready_out !== 1'b0) begin errors++; $display("FAIL wr_setup_hready got %b exp 0", hready_out); end
    checks++; if (paddr !== 32'h8000_0010 || pwrite !== 1'b1) begin errors++; $display("FAIL wr_setup_addr got %h/%b exp 80000010/1", paddr, pwrite); end
    step();
    checks++; if (psel !== 3'b001 || penable !== 1'b1) begin errors++; $display("FAIL wr_access got psel %b pen %b exp 001/1", psel, penable); end
    checks++; if (pwdata !== 32'hA5A5_0001) begin errors++; $display("FAIL wr_access_pwdata got %h exp a5a50001", pwdata); end
    checks++; if (hready_out !== 1'b1) begin errors++; $display("FAIL wr_access_hready got %b exp 1", hready_out); end
    step();
    checks++; if (xfer_cnt !== 16'd1) begin errors++; $display("FAIL wr_cnt got %0d exp 1", xfer_cnt); end
    checks++; if (psel !== 3'b000 || penable !== 1'b0) begin errors++; $display("FAIL wr_idle got psel %b pen %b exp 000/0", psel, penable); end
    checks++; if (rd_valid !== 1'b0 || hrdata !== 32'd0) begin errors++; $display("FAIL wr_no_rdata got %b/%h exp 0/0", rd_valid, hrdata); end
  endtask

  task automatic test_read();
    valid = 1'b1; hwrite = 1'b0; haddr = 32'h8800_0004; hwdata = 32'hDEAD_BEEF;
    step();
    valid = 1'b0; prdata = 32'd25;
    checks++; if (psel !== 3'b100 || penable !== 1'b0) begin errors++; $display("FAIL rd_setup got psel %b pen %b exp 100/0", psel, penable); end
    step();
    checks++; if (psel !== 3'b100 || penable !== 1'b1) begin errors++; $display("FAIL rd_access got psel %b pen %b exp 100/1", psel, penable); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_early_valid got %b exp 0", rd_valid); end
    step();
    prdata = 32'd99;
    checks++; if (hrdata !== 32'd25 || rd_valid !== 1'b1) begin errors++; $display("FAIL rd_return got %0d/%b exp 25/1", hrdata, rd_valid); end
    checks++; if (xfer_cnt !== 16'd2) begin errors++; $display("FAIL rd_cnt got %0d exp 2", xfer_cnt); end
    step();
    checks++; if (rd_valid !== 1'b0 || hrdata !== 32'd25) begin errors++; $display("FAIL rd_hold got %b/%0d exp 0/25", rd_valid, hrdata); end
  endtask

  task automatic test_back_to_back();
    valid = 1'b1; hwrite = 1'b1; haddr = 32'h8400_0000; hwdata = 32'h0000_1111;
    step();
    checks++; if (psel !== 3'b010 || penable !== 1'b0) begin errors++; $display("FAIL b2b_setup1 got %b/%b exp 010/0", psel, penable); end
    hwrite = 1'b0; haddr = 32'h8000_0008; hwdata = 32'h0000_2222;
    step();
    checks++; if (psel !== 3'b010 || penable !== 1'b1) begin errors++; $display("FAIL b2b_access1 got %b/%b exp 010/1", psel, penable); end
    checks++; if (paddr !== 32'h8400_0000 || pwdata !== 32'h0000_1111) begin errors++; $display("FAIL b2b_setup_ignore got %h/%h exp 84000000/00001111", paddr, pwdata); end
    prdata = 32'd77;
    step();
    checks++; if (psel !== 3'b001 || penable !== 1'b0 || paddr !== 32'h8000_0008) begin errors++; $display("FAIL b2b_setup2 got %b/%b/%h exp 001/0/80000008", psel, penable, paddr); end
    checks++; if (xfer_cnt !== 16'd3) begin errors++; $display("FAIL b2b_cnt1 got %0d exp 3", xfer_cnt); end
    hwrite = 1'b1; haddr = 32'h8800_0000; hwdata = 32'h0000_3333;
    step();
    checks++; if (psel !== 3'b001 || penable !== 1'b1) begin errors++; $display("FAIL b2b_access2 got %b/%b exp 001/1", psel, penable); end
    step();
    valid = 1'b0;
    checks++; if (psel !== 3'b100 || penable !== 1'b0) begin errors++; $display("FAIL b2b_setup3 got %b/%b exp 100/0", psel, penable); end
    checks++; if (rd_valid !== 1'b1 || hrdata !== 32'd77) begin errors++; $display("FAIL b2b_rd_overlap got %b/%0d exp 1/77", rd_valid, hrdata); end
    checks++; if (xfer_cnt !== 16'd4) begin errors++; $display("FAIL b2b_cnt2 got %0d exp 4", xfer_cnt); end
    step();
    step();
    checks++; if (xfer_cnt !== 16'd5 || hrdata !== 32'd77 || rd_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got %0d/%0d/%b exp 5/77/0", xfer_cnt, hrdata, rd_valid); end
  endtask

  task automatic test_decode_miss();
    valid = 1'b1; hwrite = 1'b0; haddr = 32'h1234_0000; hwdata = 32'hFFFF_FFFF;
    step();
    valid = 1'b0;
    checks++; if (herr !== 1'b1) begin errors++; $display("FAIL miss_herr got %b exp 1", herr); end
    checks++; if (psel !== 3'b000 || penable !== 1'b0 || hready_out !== 1'b1) begin errors++; $display("FAIL miss_bus got %b/%b/%b exp 000/0/1", psel, penable, hready_out); end
    checks++; if (paddr !== 32'h8800_0000 || pwdata !== 32'h0000_3333 || pwrite !== 1'b1) begin errors++; $display("FAIL miss_no_capture got %h/%h/%b exp 88000000/00003333/1", paddr, pwdata, pwrite); end
    step();
    checks++; if (herr !== 1'b0 || xfer_cnt !== 16'd5 || psel !== 3'b000) begin errors++; $display("FAIL miss_after got %b/%0d/%b exp 0/5/000", herr, xfer_cnt, psel); end
  endtask

  task automatic test_saturation();
    valid = 1'b1; hwrite = 1'b1; haddr = 32'h8000_0000; hwdata = 32'h5;
    for (int i = 0; i < 17; i++) begin
      step();
      if (i == 16) valid = 1'b0;
      step();
    end
    step();
    checks++; if (xfer_cnt !== 16'd22) begin errors++; $display("FAIL sat_main_cnt got %0d exp 22", xfer_cnt); end
    checks++; if (s_xfer_cnt !== 4'hF) begin errors++; $display("FAIL sat_cnt got %h exp f", s_xfer_cnt); end
  endtask

  task automatic test_reset_mid_setup();
    valid = 1'b1; hwrite = 1'b0; haddr = 32'h8400_0040;
    step();
    valid = 1'b0;
    checks++; if (psel !== 3'b010) begin errors++; $display("FAIL pre_reset_psel got %b exp 010", psel); end
    #2 hreset = 1'b1;
    #1;
    checks++; if (psel !== 3'b000 || penable !== 1'b0 || hready_out !== 1'b1) begin errors++; $display("FAIL midreset_bus got %b/%b/%b exp 000/0/1", psel, penable, hready_out); end
    checks++; if (xfer_cnt !== 16'd0 || hrdata !== 32'd0 || paddr !== 32'd0) begin errors++; $display("FAIL midreset_regs got %0d/%h/%h exp 0/0/0", xfer_cnt, hrdata, paddr); end
    step();
    hreset = 1'b0;
    step();
    checks++; if (psel !== 3'b000 || penable !== 1'b0 || xfer_cnt !== 16'd0) begin errors++; $display("FAIL post_reset got %b/%b/%0d exp 000/0/0", psel, penable, xfer_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read();
    test_back_to_back();
    test_decode_miss();
    test_saturation();
    test_reset_mid_setup();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
